bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential binary-to-BCD converter (shift-add-3 / double-dabble, one bit per clock) that feeds the ones/tens digit pins of the display top level. It accepts a binary value from an upstream counter or the multicycle CPU's output register. It iterates over `WIDTH` cycles and presents packed BCD digits with a one-cycle completion pulse. Results are registered and held, so the consumer can sample them at any time, including from a slow half-second domain.

## Interface
- `WIDTH`, 8: width of binary input, ≥1.
- `DIGITS`, 3: number of BCD output digits, ≥1.
- `CLK` input 1: single clock (16 MHz on board); all state updates on rising edge.
- `RESETn` input 1: reset, asynchronous assert, active-low.
- `start` input 1: conversion request; sampled only in IDLE.
- `bin` input `WIDTH`: binary value; captured on the accepted `start` edge only.
- `busy` output 1: high while a conversion is in progress.
- `valid` output 1: one-cycle pulse when `bcd` updates.
- `bcd` output `4*DIGITS`: packed result, digit 0 (ones) in [3:0], digit 1 (tens) in [7:4], etc.
- `ovf` output 1: input exceeded 10^DIGITS−1 (see Configuration).

## Operation
- States: IDLE, SHIFT. No other states.
- IDLE, `start`=1:
  - Capture `bin` into a shift register.
  - Clear scratch digits and the overflow accumulator.
  - Load iteration counter with `WIDTH`.
  - Go to SHIFT.
- IDLE, `start`=0: hold.
- SHIFT iteration, per cycle, on the scratch digits:
  - Add 3 to every scratch digit ≥5.
  - Shift {scratch digits, shift register} left by 1.
  - The bit shifted out of the top digit ORs into the overflow accumulator.
  - Decrement the counter.
- SHIFT, last iteration (counter==1):
  - Write the adjusted/shifted scratch to `bcd`.
  - Write the overflow result to `ovf`.
  - Pulse `valid`; return to IDLE.
- `start` while in SHIFT is ignored and is not queued. `bin` changes during SHIFT have no effect.
- Digits above the top are truncated, so without saturation `bcd` is exactly `bin` mod 10^DIGITS.
- `bcd`/`ovf` hold their last value until the next completion.
- Counter width: clog2(`WIDTH`+1) bits.

## Timing
- Reset values: `bcd`=0, `ovf`=0, `valid`=0, `busy`=0, state IDLE.
- Reset asserted mid-conversion aborts it: no `valid`, `bcd` returns to 0.
- `start` accepted at edge k:
  - `busy`=1 after edge k.
  - Iterations occur at edges k+1 … k+`WIDTH`.
  - At edge k+`WIDTH`: `bcd`/`ovf` update, `valid`=1 for exactly that cycle, `busy`=0.
- Latency: `WIDTH` cycles start-to-valid.
- Throughput: one conversion per `WIDTH`+1 cycles (a new `start` is accepted at the earliest at edge k+`WIDTH`+1).
- `start` held high continuously restarts immediately on each return to IDLE, capturing the then-current `bin`.
- `valid` and `busy` are never high in the same cycle.

## Configuration
- Macro `BIN2BCD_SAT_EN`.
- Defined:
  - If any bit is shifted out of the top digit during a conversion, `bcd` is written as all digits = 9 and `ovf`=1.
  - Otherwise normal result with `ovf`=0.
- Undefined:
  - Modulo result as above.
  - `ovf` is tied to 0 and no overflow accumulator is built.

## Test plan
- Defaults, `bin`=255, `start` pulse → after 8 cycles `valid` pulse, `bcd`=0x255, `ovf`=0; `busy` high exactly 8 cycles.
- `bin`=0 then `bin`=99 back-to-back with `start` held high → two `valid` pulses 9 cycles apart, `bcd`=0x000 then 0x099.
- `start` re-pulsed with `bin`=7 at cycle 3 of a `bin`=128 conversion → ignored; result `bcd`=0x128; exactly one `valid`.
- `DIGITS`=2, `bin`=200:
  - With `BIN2BCD_SAT_EN` → `bcd`=0x99, `ovf`=1.
  - Without → `bcd`=0x00, `ovf`=0.
  - Same bench with `bin`=99 → `bcd`=0x99, `ovf`=0 in both builds.
- `RESETn` low for 1 cycle at iteration 4 of `bin`=255 → `busy`/`bcd` 0 immediately; no `valid`; next `start` with `bin`=42 → `bcd`=0x042.
- Exhaustive sweep `bin`=0…255 (defaults) → every result equals the decimal digits of `bin`; each `valid` is exactly one cycle wide.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock.
// Define BIN2BCD_SAT_EN to saturate to all-nines with ovf when the input exceeds the digit range.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      sh_q, sh_d;
    logic [4*DIGITS-1:0]   dig_q, dig_d, dig_n, bcd_q, bcd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic [3:0]            adj;
    logic                  carry;
`ifdef BIN2BCD_SAT_EN
    logic                  acc_q, acc_d, ovf_q, ovf_d;
`endif

    // Add-3 then shift; carry ripples from the binary MSB up through each digit and ends as the bit lost off the top.
    always_comb begin
        carry = sh_q[WIDTH-1];
        adj   = 4'd0;
        dig_n = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj = dig_q[4*i +: 4] >= 4'd5 ? dig_q[4*i +: 4] + 4'd3 : dig_q[4*i +: 4];
            dig_n[4*i +: 4] = {adj[2:0], carry};
            carry = adj[3];
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        valid_d = 1'b0;
`ifdef BIN2BCD_SAT_EN
        acc_d   = acc_q;
        ovf_d   = ovf_q;
`endif
        if (state_q == IDLE) begin
            if (start) begin
                state_d = SHIFT;
                sh_d    = bin;
                dig_d   = '0;
                cnt_d   = CW'(WIDTH);
`ifdef BIN2BCD_SAT_EN
                acc_d   = 1'b0;
`endif
            end
        end else begin
            sh_d  = sh_q << 1;
            dig_d = dig_n;
            cnt_d = cnt_q - CW'(1);
`ifdef BIN2BCD_SAT_EN
            acc_d = acc_q | carry;
`endif
            if (cnt_q == CW'(1)) begin
                state_d = IDLE;
                valid_d = 1'b1;
`ifdef BIN2BCD_SAT_EN
                bcd_d   = (acc_q | carry) ? {DIGITS{4'h9}} : dig_n;
                ovf_d   = acc_q | carry;
`else
                bcd_d   = dig_n;
`endif
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
            sh_q    <= '0;
            dig_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
`ifdef BIN2BCD_SAT_EN
            acc_q   <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
`ifdef BIN2BCD_SAT_EN
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy  = state_q == SHIFT;
    assign valid = valid_q;
    assign bcd   = bcd_q;
`ifdef BIN2BCD_SAT_EN
    assign ovf   = ovf_q;
`else
    assign ovf   = 1'b0;
`endif
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: randomized and directed checks of bin_to_bcd_seq against a decimal-arithmetic model.
module tb_bin_to_bcd_seq;
    localparam int W = 8;
    localparam int D = 3;

    logic          CLK = 1'b0, RESETn = 1'b0, start = 1'b0, start2 = 1'b0;
    logic [W-1:0]  bin = '0, bin2 = '0;
    logic          busy, valid, ovf, busy2, valid2, ovf2;
    logic [11:0]   bcd;
    logic [7:0]    bcd2;
    int            total = 0, bad = 0;
    bit            chk_en = 1'b0;

    logic          m_busy, m_valid, m_ovf;
    logic [11:0]   m_bcd;
    int            m_cnt, m_val;

    always #5 CLK = ~CLK;

    bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D)) u_dut (
        .CLK(CLK), .RESETn(RESETn), .start(start), .bin(bin),
        .busy(busy), .valid(valid), .bcd(bcd), .ovf(ovf));

    bin_to_bcd_seq #(.WIDTH(W), .DIGITS(2)) u_dut2 (
        .CLK(CLK), .RESETn(RESETn), .start(start2), .bin(bin2),
        .busy(busy2), .valid(valid2), .bcd(bcd2), .ovf(ovf2));

    function automatic int lim_of(int d);
        int l = 1;
        for (int i = 0; i < d; i++) l = l * 10;
        return l;
    endfunction

    function automatic logic ref_ovf(int v, int d);
`ifdef BIN2BCD_SAT_EN
        return v >= lim_of(d);
`else
        return 1'b0;
`endif
    endfunction

    // Decimal digits of v, truncated to d digits (or all nines when saturating).
    function automatic logic [31:0] ref_bcd(int v, int d);
        logic [31:0] r = '0;
        int x = v % lim_of(d);
        if (ref_ovf(v, d)) x = lim_of(d) - 1;
        for (int i = 0; i < d; i++) begin
            r = r | (32'(x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-level model: WIDTH cycles after an accepted start the result appears for one cycle.
    always @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_ovf <= 1'b0; m_bcd <= '0; m_cnt <= 0; m_val <= 0;
        end else begin
            m_valid <= 1'b0;
            if (m_busy) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_busy  <= 1'b0;
                    m_valid <= 1'b1;
                    m_bcd   <= 12'(ref_bcd(m_val, D));
                    m_ovf   <= ref_ovf(m_val, D);
                end
            end else if (start) begin
                m_val  <= int'(bin);
                m_cnt  <= W;
                m_busy <= 1'b1;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("valid", 32'(valid), 32'(m_valid));
            check("bcd", 32'(bcd), 32'(m_bcd));
            check("ovf", 32'(ovf), 32'(m_ovf));
            check("busy_and_valid", 32'(busy & valid), 32'd0);
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_valid(input bit second);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (second ? valid2 : valid) return;
        end
        check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic convert(input int v);
        tick(); bin = W'(v); start = 1'b1;
        tick(); start = 1'b0;
    endtask

    int nb, nv, c1, c2;
    logic [11:0] got, got2;

    initial begin
        repeat (2) tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_bcd", 32'(bcd), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        RESETn = 1'b1;
        chk_en = 1'b1;

        // Single 255 conversion: busy exactly 8 cycles, one valid.
        convert(255);
        nb = 0; nv = 0; got = '0;
        for (int i = 0; i < 12; i++) begin
            if (busy) nb++;
            if (valid) begin nv++; got = bcd; end
            tick();
        end
        check("busy_cycles", 32'(nb), 32'd8);
        check("valid_count_255", 32'(nv), 32'd1);
        check("bcd_255", 32'(got), 32'h255);
        check("model_255", 32'(m_bcd), 32'h255);

        // start held high: 0 then 99 back-to-back.
        tick(); bin = 8'd0; start = 1'b1;
        tick(); bin = 8'd99;
        nv = 0; c1 = 0; c2 = 0; got = '0; got2 = '0;
        for (int i = 0; i < 30 && nv < 2; i++) begin
            tick();
            if (valid) begin
                nv++;
                if (nv == 1) begin c1 = i; got = bcd; end
                else begin c2 = i; got2 = bcd; end
            end
        end
        start = 1'b0;
        check("held_valid_count", 32'(nv), 32'd2);
        check("held_spacing", 32'(c2 - c1), 32'd9);
        check("held_first", 32'(got), 32'h000);
        check("held_second", 32'(got2), 32'h099);
        repeat (12) tick();

        // start re-pulse during a conversion is ignored.
        convert(128);
        tick(); bin = 8'd7; start = 1'b1;
        tick(); start = 1'b0;
        nv = 0; got = '0;
        for (int i = 0; i < 14; i++) begin
            if (valid) begin nv++; got = bcd; end
            tick();
        end
        check("ignore_valid_count", 32'(nv), 32'd1);
        check("ignore_bcd", 32'(got), 32'h128);

        // Reset mid-conversion aborts without valid.
        convert(255);
        repeat (3) tick();
        RESETn = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
        tick(); RESETn = 1'b1;
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            if (valid) nv++;
            tick();
        end
        check("abort_no_valid", 32'(nv), 32'd0);
        convert(42);
        wait_valid(1'b0);
        check("after_abort_42", 32'(bcd), 32'h042);

        // Exhaustive sweep.
        for (int v = 0; v < 256; v++) begin
            convert(v);
            wait_valid(1'b0);
            check("sweep", 32'(bcd), ref_bcd(v, D));
        end

        // Random start/bin traffic checked by the per-cycle model.
        for (int i = 0; i < 600; i++) begin
            tick();
            bin = W'($urandom);
            start = ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        repeat (12) tick();

        // Two-digit instance: out-of-range and in-range values.
        tick(); bin2 = 8'd200; start2 = 1'b1;
        tick(); start2 = 1'b0;
        wait_valid(1'b1);
`ifdef BIN2BCD_SAT_EN
        check("d2_200_bcd", 32'(bcd2), 32'h99);
        check("d2_200_ovf", 32'(ovf2), 32'd1);
`else
        check("d2_200_bcd", 32'(bcd2), 32'h00);
        check("d2_200_ovf", 32'(ovf2), 32'd0);
`endif
        tick(); bin2 = 8'd99; start2 = 1'b1;
        tick(); start2 = 1'b0;
        wait_valid(1'b1);
        check("d2_99_bcd", 32'(bcd2), 32'h99);
        check("d2_99_ovf", 32'(ovf2), 32'd0);
        check("d2_busy_idle", 32'(busy2), 32'd0);

        repeat (2) tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
